// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data-memory access unit. Turns EX/MEM load/store controls into a
//   req/ack data-bus transaction, forms byte enables and replicated store data,
//   extends load data for MEM/WB, stalls the pipeline while an access is
//   outstanding and flags misaligned/illegal and timed-out accesses.
// Ports
//   clk, reset_n                   clock (rising edge), async active-low reset
//   mem_valid_i/mem_rd_i/mem_wr_i  EX/MEM valid, load, store
//   funct3_i, addr_i, wr_data_i    access size/sign, byte address, store data
//   mem_rd_data_o                  extended load data to MEM/WB
//   stall_o                        hold upstream pipeline registers
//   addr_err_o                     misaligned/illegal access (no bus cycle)
//   bus_err_o                      one-cycle pulse when an access timed out
//   bus_req_o/we/addr/be/wdata     data-bus request side
//   bus_rdata_i, bus_ack_i         data-bus response side
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] mem_rd_data_o,
  output logic        stall_o,
  output logic        addr_err_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_INT);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [31:0]       addr_reg;
  logic [3:0]        be_reg;
  logic [31:0]       wdata_reg;
  logic [2:0]        funct3_reg;
  logic [1:0]        lane_reg;
  logic [31:0]       rd_data_reg;
  logic              err_reg;

  logic        in_idle, in_busy;
  logic        legal_f3, aligned, start, timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] byte_rep, half_rep;

  // Lane replication of store data so any byte/half lane sees the operand.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_rep
    assign byte_rep[gi*8 +: 8] = wr_data_i[7:0];
  end
  for (genvar gi = 0; gi < 2; gi++) begin : g_half_rep
    assign half_rep[gi*16 +: 16] = wr_data_i[15:0];
  end

  // Select the addressed lane and sign/zero-extend it (funct3[2] = unsigned).
  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [1:0] lane,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    in_idle  = (state_reg == IDLE);
    in_busy  = (state_reg == BUSY);
    legal_f3 = !((funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111));
    case (funct3_i[1:0])
      2'b01:   aligned = !addr_i[0];
      2'b10:   aligned = (addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    // reset_n gates the combinational outputs so every output is 0 while in reset.
    start      = reset_n & in_idle & mem_valid_i & (mem_rd_i ^ mem_wr_i) & aligned & legal_f3;
    addr_err_o = reset_n & in_idle & mem_valid_i & (mem_rd_i | mem_wr_i) & !start;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST) && !bus_ack_i;

    case (funct3_i[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = byte_rep;
      end
      2'b01: begin
        be_next    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = half_rep;
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wr_data_i;
      end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (bus_ack_i || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;  // never re-issue a held instruction
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      be_reg      <= '0;
      wdata_reg   <= '0;
      funct3_reg  <= '0;
      lane_reg    <= '0;
      rd_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      // timeout_hit already excludes ack, so ack on the last cycle wins.
      err_reg   <= in_busy && timeout_hit;
      if (start) begin
        we_reg     <= mem_wr_i;
        addr_reg   <= {addr_i[31:2], 2'b00};
        be_reg     <= be_next;
        wdata_reg  <= wdata_next;
        funct3_reg <= funct3_i;
        lane_reg   <= addr_i[1:0];
        cnt_reg    <= '0;
      end else if (in_busy) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      if (in_busy) begin
        if (bus_ack_i) begin
          if (!we_reg) rd_data_reg <= extend_load(funct3_reg, lane_reg, bus_rdata_i);
        end else if (timeout_hit) begin
          rd_data_reg <= '0;
        end
      end
    end
  end

  assign stall_o       = start | in_busy;
  assign bus_req_o     = in_busy;
  assign bus_err_o     = err_reg;
  assign bus_we_o      = we_reg;
  assign bus_addr_o    = addr_reg;
  assign bus_be_o      = be_reg;
  assign bus_wdata_o   = wdata_reg;
  assign mem_rd_data_o = rd_data_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed-vector bench for mem_access_unit (TIMEOUT_CYCLES = 4). Each access
//   is driven through one task that counts stall/request/error cycles and
//   captures the bus fields; results go through a single checking task.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] mem_rd_data;
  logic        stall;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the most recent access
  int          stall_n, req_n, err_n;
  logic        done_seen;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata, rd_seen;
  logic [3:0]  cap_be;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_valid_i   (mem_valid),
    .mem_rd_i      (mem_rd),
    .mem_wr_i      (mem_wr),
    .funct3_i      (funct3),
    .addr_i        (addr),
    .wr_data_i     (wr_data),
    .mem_rd_data_o (mem_rd_data),
    .stall_o       (stall),
    .addr_err_o    (addr_err),
    .bus_err_o     (bus_err),
    .bus_req_o     (bus_req),
    .bus_we_o      (bus_we),
    .bus_addr_o    (bus_addr),
    .bus_be_o      (bus_be),
    .bus_wdata_o   (bus_wdata),
    .bus_rdata_i   (bus_rdata),
    .bus_ack_i     (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one access; ack on the ack_at-th BUSY cycle (0 = never ack).
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdat);
    int busy_n;
    busy_n = 0; stall_n = 0; req_n = 0; err_n = 0; done_seen = 1'b0;
    cap_we = 1'b0; cap_addr = '0; cap_wdata = '0; cap_be = '0; rd_seen = '0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wr_data = wd;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (bus_req) begin
        busy_n++;
        bus_ack   = (busy_n == ack_at);
        bus_rdata = rdat;
      end else begin
        bus_ack = 1'b0;
      end
      #1;
      if (stall) stall_n++;
      if (bus_err) err_n++;
      if (bus_req) begin
        req_n++;
        cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be;
      end
      if (c > 0 && !stall) begin
        done_seen = 1'b1;
        rd_seen   = mem_rd_data;
      end
    end
    bus_ack = 1'b0;
    check("access_completed", {31'd0, done_seen}, 32'd1);
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    #1;
    if (bus_err) err_n++;
    $display("txn rd=%0b wr=%0b f3=%03b addr=%h wdata=%h -> stall=%0d req=%0d err=%0d be=%04b bus_addr=%h bus_wdata=%h rd_data=%h",
             rd, wr, f3, a, wd, stall_n, req_n, err_n, cap_be, cap_addr, cap_wdata, rd_seen);
  endtask

  // Misaligned/illegal request: flagged at once, no stall, no bus cycle.
  task automatic err_case(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd_keep);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a;
    #1;
    check({tag, "_addr_err"}, {31'd0, addr_err}, 32'd1);
    check({tag, "_stall"},    {31'd0, stall},    32'd0);
    check({tag, "_req"},      {31'd0, bus_req},  32'd0);
    @(posedge clk); #2;
    check({tag, "_req_later"}, {31'd0, bus_req}, 32'd0);
    check({tag, "_rd_data"},   mem_rd_data,      rd_keep);
    mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    $display("txn error rd=%0b wr=%0b f3=%03b addr=%h", rd, wr, f3, a);
  endtask

  initial begin
    // Reset with a valid load held on the inputs: everything stays 0.
    mem_valid = 1'b1; mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall",    {31'd0, stall},    32'd0);
    check("rst_req",      {31'd0, bus_req},  32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_bus_err",  {31'd0, bus_err},  32'd0);
    check("rst_rd_data",  mem_rd_data,       32'd0);
    check("rst_be",       {28'd0, bus_be},   32'd0);
    mem_valid = 1'b0; mem_rd = 1'b0;
    reset_n = 1'b1;

    // SW 0x104
    access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 2, 32'h0);
    check("sw_be",    {28'd0, cap_be}, 32'h0000000F);
    check("sw_addr",  cap_addr,        32'h00000104);
    check("sw_wdata", cap_wdata,       32'hDEADBEEF);
    check("sw_we",    {31'd0, cap_we}, 32'd1);
    check("sw_stall", stall_n,         32'd3);
    check("sw_req",   req_n,           32'd2);
    check("sw_err",   err_n,           32'd0);

    // SB 0x203
    access(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 1, 32'h0);
    check("sb_be",    {28'd0, cap_be}, 32'h00000008);
    check("sb_wdata", cap_wdata,       32'hA5A5A5A5);
    check("sb_we",    {31'd0, cap_we}, 32'd1);
    check("sb_addr",  cap_addr,        32'h00000200);

    // LB / LBU / LH
    access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 1, 32'h00008000);
    check("lb_data",  rd_seen,         32'hFFFFFF80);
    check("lb_we",    {31'd0, cap_we}, 32'd0);
    check("lb_stall", stall_n,         32'd2);
    access(1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 1, 32'h00008000);
    check("lbu_data", rd_seen,         32'h00000080);
    access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 3, 32'h80000000);
    check("lh_data",  rd_seen,         32'hFFFF8000);
    check("lh_be",    {28'd0, cap_be}, 32'h0000000C);
    check("lh_req",   req_n,           32'd3);

    // SH 0x106: lanes 3:2, load result untouched
    access(1'b0, 1'b1, 3'b001, 32'h106, 32'h00001234, 1, 32'h0);
    check("sh_be",      {28'd0, cap_be}, 32'h0000000C);
    check("sh_wdata",   cap_wdata,       32'h12341234);
    check("sh_rd_keep", rd_seen,         32'hFFFF8000);

    // Misaligned / illegal
    err_case("lw_misal", 1'b1, 1'b0, 3'b010, 32'h102, 32'hFFFF8000);
    err_case("lh_misal", 1'b1, 1'b0, 3'b001, 32'h001, 32'hFFFF8000);
    err_case("bad_f3",   1'b1, 1'b0, 3'b011, 32'h100, 32'hFFFF8000);
    err_case("rd_wr",    1'b1, 1'b1, 3'b010, 32'h100, 32'hFFFF8000);

    // Timeout: never ack
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h0);
    check("to_req",   req_n,   32'd4);
    check("to_stall", stall_n, 32'd5);
    check("to_err",   err_n,   32'd1);
    check("to_data",  rd_seen, 32'h00000000);

    // Ack on the timeout cycle wins
    access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 4, 32'h11223344);
    check("ackto_req",  req_n,   32'd4);
    check("ackto_err",  err_n,   32'd0);
    check("ackto_data", rd_seen, 32'h11223344);

    // Reset in BUSY, then clean re-issue of the held load
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h108;
    @(posedge clk); #1;
    check("mid_busy_req", {31'd0, bus_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req",   {31'd0, bus_req}, 32'd0);
    check("mid_rst_stall", {31'd0, stall},   32'd0);
    check("mid_rst_data",  mem_rd_data,      32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("reissue_start_stall", {31'd0, stall},   32'd1);
    check("reissue_start_req",   {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    check("reissue_req",  {31'd0, bus_req}, 32'd1);
    check("reissue_addr", bus_addr,         32'h00000108);
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    check("reissue_done_stall", {31'd0, stall}, 32'd0);
    check("reissue_data",       mem_rd_data,    32'hCAFEF00D);
    mem_valid = 1'b0; mem_rd = 1'b0;
    @(posedge clk); #2;
    check("reissue_idle_req", {31'd0, bus_req}, 32'd0);
    $display("txn reset-in-busy reissue addr=00000108 rd_data=%h", mem_rd_data);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
